// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle rv32i core.
// Serves combinational loads / clocked stores from a word-indexed RAM and an
// MMIO window (TXDATA, STATUS, CTRL) in front of a byte FIFO that feeds an
// 8N1 serial transmitter.
// Optional feature: define DMEM_RESP_IRQ_EN to enable the registered
// interrupt output and the CTRL.irq_en bit; otherwise irq_o is tied to 0.
// FIFO_DEPTH must be a power of two (>= 2) and BAUD_DIV must be >= 2.

module dmem_responder #(
    parameter int          RAM_WORDS  = 512,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          BAUD_DIV   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_w_i,
    input  logic [31:0] dmem_w_data_i,
    output logic [31:0] dmem_r_data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);

    localparam logic [31:0]       RAM_LIMIT   = 32'(RAM_WORDS);
    localparam logic [31:0]       ADDR_TXDATA = MMIO_BASE;
    localparam logic [31:0]       ADDR_STATUS = MMIO_BASE + 32'd1;
    localparam logic [31:0]       ADDR_CTRL   = MMIO_BASE + 32'd2;
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Storage
    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    // FIFO bookkeeping
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    // Control register bits
    logic tx_en;
    logic irq_en;

    // Transmitter
    tx_state_t         state;
    logic [7:0]        shift_reg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;

    // Decode and handshake terms
    logic              sel_ram;
    logic              sel_txdata;
    logic              sel_status;
    logic              sel_ctrl;
    logic [RAM_AW-1:0] ram_idx;
    logic              fifo_full;
    logic              fifo_empty;
    logic              busy;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              overflow_set;
    logic              overflow_clr;
    logic              ctrl_wr;
    logic [31:0]       status_word;
    logic [31:0]       ctrl_word;

    // Data bits above the byte lane carry nothing for any MMIO register.
    logic unused_wdata_bits;
    assign unused_wdata_bits = ^dmem_w_data_i[31:8];

    assign sel_ram    = (dmem_addr_i < RAM_LIMIT);
    assign sel_txdata = (dmem_addr_i == ADDR_TXDATA);
    assign sel_status = (dmem_addr_i == ADDR_STATUS);
    assign sel_ctrl   = (dmem_addr_i == ADDR_CTRL);
    assign ram_idx    = dmem_addr_i[RAM_AW-1:0];

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);

    // The transmitter only pulls a byte while idle, enabled and data is waiting.
    assign pop      = (state == IDLE) && tx_en && !fifo_empty;
    assign push_req = dmem_w_i && sel_txdata;

    // A push into a full FIFO still fits if a slot frees up on the same edge.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign overflow_clr = dmem_w_i && sel_status && dmem_w_data_i[3];
    assign ctrl_wr      = dmem_w_i && sel_ctrl;

    // Build the STATUS word from live FIFO/transmitter state.
    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_full;
        status_word[1]    = fifo_empty;
        status_word[2]    = busy;
        status_word[3]    = overflow;
        status_word[11:8] = 4'(count);
    end

    assign ctrl_word = {30'b0, irq_en, tx_en};

    // Load path: zero-latency read mux; unmapped addresses and TXDATA read 0.
    always_comb begin
        dmem_r_data_o = '0;
        if (sel_ram) begin
            dmem_r_data_o = ram[ram_idx];
        end else if (sel_status) begin
            dmem_r_data_o = status_word;
        end else if (sel_ctrl) begin
            dmem_r_data_o = ctrl_word;
        end
    end

    // RAM store: full word commits at the edge, contents survive reset.
    always_ff @(posedge clk) begin
        if (dmem_w_i && sel_ram) begin
            ram[ram_idx] <= dmem_w_data_i;
        end
    end

    // FIFO storage; reset only clears the pointers, which discards old entries.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= dmem_w_data_i[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DMEM_RESP_IRQ_EN
    // CTRL register with both the transmit-enable and interrupt-enable bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            tx_en  <= dmem_w_data_i[0];
            irq_en <= dmem_w_data_i[1];
        end
    end

    // Interrupt on overflow or when the transmitter has fully drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_en & (overflow | (fifo_empty & ~busy));
        end
    end
`else
    // CTRL register holds only the transmit-enable bit in this build.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en <= 1'b1;
        end else if (ctrl_wr) begin
            tx_en <= dmem_w_data_i[0];
        end
    end

    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // 8N1 transmitter: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_o      <= 1'b1;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        tx_o      <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_o     <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_o      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx_o <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, table-driven bench for dmem_responder
// (default parameters). Honours DMEM_RESP_IRQ_EN for the interrupt checks.

module tb_dmem_responder;

    localparam logic [31:0] MMIO   = 32'h1000_0000;
    localparam logic [31:0] TXDATA = MMIO;
    localparam logic [31:0] STATUS = MMIO + 32'd1;
    localparam logic [31:0] CTRL   = MMIO + 32'd2;
    localparam int          BAUD   = 16;
    localparam int          FRAME  = 10 * BAUD;

`ifdef DMEM_RESP_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] dmem_addr_i;
    logic        dmem_w_i;
    logic [31:0] dmem_w_data_i;
    logic [31:0] dmem_r_data_o;
    logic        tx_o;
    logic        irq_o;

    int checks;
    int passes;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [20];

    dmem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_addr_i   (dmem_addr_i),
        .dmem_w_i      (dmem_w_i),
        .dmem_w_data_i (dmem_w_data_i),
        .dmem_r_data_o (dmem_r_data_o),
        .tx_o          (tx_o),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInputs(input logic w, input logic [31:0] addr, input logic [31:0] data);
        dmem_w_i      = w;
        dmem_addr_i   = addr;
        dmem_w_data_i = data;
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] addr, input logic [31:0] data);
        driveInputs(w, addr, data);
        tick();
        dmem_w_i = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    function automatic logic frameLevel(input logic [7:0] b, input int i);
        if (i < BAUD) return 1'b0;
        if (i < 9 * BAUD) return b[(i - BAUD) / BAUD];
        return 1'b1;
    endfunction

    logic [7:0] exp_bytes [9];

    initial begin
        int bad;
        checks        = 0;
        passes        = 0;
        reset         = 1'b1;
        dmem_w_i      = 1'b0;
        dmem_addr_i   = '0;
        dmem_w_data_i = '0;

        repeat (3) tick();
        driveInputs(1'b0, STATUS, 32'h0);
        checkOutput("reset_tx", {31'b0, tx_o}, 32'h1);
        checkOutput("reset_irq", {31'b0, irq_o}, 32'h0);
        checkOutput("reset_status", dmem_r_data_o, 32'h2);
        reset = 1'b0;
        tick();

        vecs[0]  = '{1'b0, STATUS,      32'h0,         1'b1, 32'h0000_0002};
        vecs[1]  = '{1'b0, CTRL,        32'h0,         1'b1, 32'h0000_0001};
        vecs[2]  = '{1'b0, TXDATA,      32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'd5,       32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'd5,       32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'd6,       32'h1234_5678, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'd6,       32'hCAFE_F00D, 1'b1, 32'h1234_5678};
        vecs[7]  = '{1'b0, 32'd6,       32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 32'd512,     32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b1, 32'd512,     32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'd512,     32'h0,         1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'd511,     32'h0000_0011, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'd511,     32'h0,         1'b1, 32'h0000_0011};
        vecs[13] = '{1'b0, MMIO + 32'd7, 32'h0,        1'b1, 32'h0};
        vecs[14] = '{1'b1, CTRL,        32'hFFFF_FFFE, 1'b0, 32'h0};
        vecs[15] = '{1'b0, CTRL,        32'h0,         1'b1, {30'b0, IRQ_ON, 1'b0}};
        vecs[16] = '{1'b1, CTRL,        32'h0000_0001, 1'b0, 32'h0};
        vecs[17] = '{1'b0, CTRL,        32'h0,         1'b1, 32'h0000_0001};
        vecs[18] = '{1'b0, 32'd5,       32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[19] = '{1'b0, MMIO + 32'd3, 32'h0,        1'b1, 32'h0};

        for (int i = 0; i < 20; i++) begin
            driveInputs(vecs[i].w, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), dmem_r_data_o, vecs[i].exp);
            tick();
            dmem_w_i = 1'b0;
        end

        // Single byte 0xA5: start bit one edge after the write edge.
        applyStimulus(1'b1, TXDATA, 32'hFFFF_FFA5);
        driveInputs(1'b0, STATUS, 32'h0);
        checkOutput("a5_before_start", {31'b0, tx_o}, 32'h1);
        tick();
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < BAUD; c++) begin
                if (tx_o !== frameLevel(8'hA5, b * BAUD + c)) bad++;
                if (b == 4 && c == 8) checkOutput("a5_status_busy", dmem_r_data_o, 32'h6);
                tick();
            end
            checkOutput($sformatf("a5_bit%0d", b), bad, 0);
        end
        checkOutput("a5_status_done", dmem_r_data_o, 32'h2);

        // Fill with transmitter disabled, overflow, clear, then drain.
        applyStimulus(1'b1, CTRL, 32'h0);
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, TXDATA, 32'h10 + k);
        driveInputs(1'b0, STATUS, 32'h0);
        checkOutput("fill_status_ovf", dmem_r_data_o, 32'h0000_0809);
        checkOutput("fill_tx_idle", {31'b0, tx_o}, 32'h1);
        applyStimulus(1'b1, STATUS, 32'h0000_0008);
        driveInputs(1'b0, STATUS, 32'h0);
        checkOutput("fill_status_w1c", dmem_r_data_o, 32'h0000_0801);
        applyStimulus(1'b1, CTRL, 32'h1);
        applyStimulus(1'b1, TXDATA, 32'h55);
        driveInputs(1'b0, STATUS, 32'h0);
        checkOutput("pushpop_status", dmem_r_data_o, 32'h0000_0805);
        for (int k = 0; k < 8; k++) exp_bytes[k] = 8'(8'h10 + k);
        exp_bytes[8] = 8'h55;
        for (int k = 0; k < 9; k++) begin
            bad = 0;
            for (int i = 0; i <= FRAME; i++) begin
                if (tx_o !== frameLevel(exp_bytes[k], i)) bad++;
                tick();
            end
            checkOutput($sformatf("frame%0d", k), bad, 0);
        end
        checkOutput("drain_status", dmem_r_data_o, 32'h2);

        // Reset in the middle of data bit 3 of a zero byte.
        applyStimulus(1'b1, CTRL, 32'h0);
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, TXDATA, 32'h0);
        applyStimulus(1'b1, CTRL, 32'h1);
        driveInputs(1'b0, STATUS, 32'h0);
        repeat (71) tick();
        checkOutput("rst_bit3_low", {31'b0, tx_o}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_tx_high", {31'b0, tx_o}, 32'h1);
        checkOutput("rst_status", dmem_r_data_o, 32'h2);
        repeat (20) tick();
        checkOutput("rst_tx_quiet", {31'b0, tx_o}, 32'h1);
        checkOutput("rst_status_quiet", dmem_r_data_o, 32'h2);
        driveInputs(1'b0, 32'd5, 32'h0);
        checkOutput("rst_ram_kept", dmem_r_data_o, 32'hDEAD_BEEF);
        driveInputs(1'b0, CTRL, 32'h0);
        checkOutput("rst_ctrl", dmem_r_data_o, 32'h1);

        // Interrupt around one frame.
        applyStimulus(1'b1, CTRL, 32'h3);
        driveInputs(1'b0, CTRL, 32'h0);
        checkOutput("irq_ctrl", dmem_r_data_o, {30'b0, IRQ_ON, 1'b1});
        tick();
        checkOutput("irq_idle", {31'b0, irq_o}, {31'b0, IRQ_ON});
        applyStimulus(1'b1, TXDATA, 32'h81);
        checkOutput("irq_after_write", {31'b0, irq_o}, {31'b0, IRQ_ON});
        tick();
        bad = 0;
        for (int i = 0; i <= FRAME; i++) begin
            if (irq_o !== 1'b0) bad++;
            tick();
        end
        checkOutput("irq_in_frame", bad, 0);
        checkOutput("irq_after_frame", {31'b0, irq_o}, {31'b0, IRQ_ON});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
